if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter WIDTH, default 32, meaning PC and instruction width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port stall, input, 1, hold request from decode.
REQ-006 SHALL have port redirect, input, 1, taken branch or jump from a later stage.
REQ-007 SHALL have port redirect_pc, input, WIDTH, branch or jump target.
REQ-008 SHALL have port imem_addr, output, WIDTH, instruction memory address (combinational read).
REQ-009 SHALL have port imem_data, input, WIDTH, instruction word returned in the same cycle.
REQ-010 SHALL have port pc_sel, output, 1, select for the next-PC mux2to1: 0 = pc+4, 1 = target.
REQ-011 SHALL have ports ifid_instr, ifid_pc4 (output, WIDTH each) and ifid_valid (output, 1), forming the IF/ID register.

Function
REQ-012 SHALL drive imem_addr directly from the PC register, with no added latency.
REQ-013 SHALL compute pc+4 modulo 2^WIDTH, so that 32'hFFFF_FFFC wraps to 32'h0.
REQ-014 SHALL force bits [1:0] of every loaded target to 2'b00.
REQ-015 SHALL use a two-state FSM: RUN and PEND; PEND holds a latched redirect target.
REQ-016 In RUN, with no stall and no redirect: pc <= pc+4; ifid_instr <= imem_data; ifid_pc4 <= pc+4; ifid_valid <= 1.
REQ-017 With stall and no redirect, PC, the IF/ID register, and the FSM state SHALL hold.
REQ-018 pc_sel SHALL be combinational and equal 1 exactly in cycles where the PC loads a redirect target.
REQ-019 Redirect behaviour without the macro: PC SHALL load the target and ifid_valid <= 0 (flush), even when stall is asserted; flush beats stall; the FSM remains in RUN.
REQ-020 Redirect behaviour with the macro: see REQ-026 and REQ-027.
REQ-021 When ifid_valid <= 0, ifid_instr and ifid_pc4 SHALL hold their previous values.

Reset
REQ-022 When rst=1 at a clock edge, reset SHALL override all other inputs.
REQ-023 On reset: pc <= RESET_PC; FSM <= RUN; pending target cleared to 0.
REQ-024 On reset: ifid_valid <= 0, ifid_instr <= 0, ifid_pc4 <= 0; pc_sel reads 0 while rst=1.
REQ-025 Reset in PEND SHALL discard the pending target.

Configuration
REQ-026 SHALL support macro BRANCH_DELAY_SLOT_EN; when defined, a redirect without stall captures the current fetch into IF/ID as a valid delay-slot instruction, and PC loads the target the same cycle.
REQ-027 With BRANCH_DELAY_SLOT_EN defined, a redirect with stall SHALL latch the target and move to PEND with PC and IF/ID held.
REQ-028 In PEND, the first cycle with no stall SHALL capture the delay slot into IF/ID, load the PC with the target (pc_sel=1), and return to RUN.
REQ-029 In PEND, a new redirect SHALL overwrite the latched target (newest wins).
REQ-030 Without BRANCH_DELAY_SLOT_EN, PEND SHALL be unreachable and REQ-019 applies.

Verification
REQ-031 Reset: RESET_PC=32'h100, release rst, no stall, 3 cycles -> imem_addr 100, 104, 108, 10C; ifid_valid 0 then 1; ifid_pc4=32'h104 after the first capture.
REQ-032 Wrap-around: pc=32'hFFFF_FFFC, no stall -> next imem_addr=32'h0; ifid_pc4=32'h0.
REQ-033 Stall: assert stall for 2 cycles at pc=32'h20 -> imem_addr stays 20; IF/ID unchanged; ifid_valid unchanged.
REQ-034 Redirect, macro off: at pc=32'h40 with imem_data=32'hAAAA_0001, redirect=1, redirect_pc=32'h203 -> next imem_addr=32'h200, ifid_valid=0, pc_sel=1 that cycle; repeat with stall=1 and expect the same result.
REQ-035 Redirect, macro on: stall=1 and redirect to 32'h300 at pc=32'h40; next cycle redirect to 32'h400; then stall=0 -> IF/ID captures the 32'h40 instruction with ifid_valid=1, and the next imem_addr=32'h400.
REQ-036 Reset in PEND (macro on): rst during PEND -> imem_addr=RESET_PC; the pending target is never loaded.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// Optional branch delay slot support is enabled by defining BRANCH_DELAY_SLOT_EN.
module if_stage #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    output logic             pc_sel,
    output logic [WIDTH-1:0] ifid_instr,
    output logic [WIDTH-1:0] ifid_pc4,
    output logic             ifid_valid
);

    typedef enum logic {StRun, StPend} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic             sel_raw;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] target;

    assign pc_plus4 = pc_q + WIDTH'(4);
    // Targets are always word aligned.
    assign target   = {redirect_pc[WIDTH-1:2], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        sel_raw = 1'b0;

        unique case (state_q)
            StRun: begin
                if (redirect) begin
                    if (stall) begin
`ifdef BRANCH_DELAY_SLOT_EN
                        pend_d  = target;
                        state_d = StPend;
`else
                        pc_d    = target;
                        valid_d = 1'b0;
                        sel_raw = 1'b1;
`endif
                    end else begin
`ifdef BRANCH_DELAY_SLOT_EN
                        instr_d = imem_data;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
`else
                        valid_d = 1'b0;
`endif
                        pc_d    = target;
                        sel_raw = 1'b1;
                    end
                end else if (!stall) begin
                    pc_d    = pc_plus4;
                    instr_d = imem_data;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                end
            end
            StPend: begin
                // Newest redirect wins over the latched target.
                if (redirect) begin
                    pend_d = target;
                end
                if (!stall) begin
                    instr_d = imem_data;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = redirect ? target : pend_q;
                    sel_raw = 1'b1;
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr  = pc_q;
    assign pc_sel     = sel_raw & ~rst;
    assign ifid_instr = instr_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_valid = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed-vector bench for if_stage; redirect expectations follow BRANCH_DELAY_SLOT_EN.
module tb_if_stage;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit Bds = 1'b1;
`else
    localparam bit Bds = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, redirect, pc_sel, ifid_valid;
    logic [31:0] redirect_pc, imem_addr, imem_data, ifid_instr, ifid_pc4;
    logic        ovr_en;
    logic [31:0] ovr_val;

    int errors = 0;
    int checks = 0;

    // Memory model: each word is its address XOR a marker, unless overridden.
    assign imem_data = ovr_en ? ovr_val : (imem_addr ^ 32'hDEAD_0000);

    always #5 clk = ~clk;

    if_stage #(
        .WIDTH   (32),
        .RESET_PC(32'h100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .pc_sel     (pc_sel),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid)
    );

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        sel;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs mid-cycle, check the combinational select, then advance one edge.
    task automatic step(input logic s, input logic r, input logic [31:0] rpc,
                        input logic exp_sel, input string name);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        #1;
        chk({name, ".pc_sel"}, {31'b0, pc_sel}, {31'b0, exp_sel});
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h104, 1'b1, 32'h104, 32'hDEAD_0100};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h108, 1'b1, 32'h108, 32'hDEAD_0104};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h10C, 1'b1, 32'h10C, 32'hDEAD_0108};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h10C, 1'b1, 32'h10C, 32'hDEAD_0108};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h10C, 1'b1, 32'h10C, 32'hDEAD_0108};
        vecs[5]  = '{1'b0, 1'b1, 32'h22, 1'b1, 32'h20, Bds,
                     Bds ? 32'h110 : 32'h10C, Bds ? 32'hDEAD_010C : 32'hDEAD_0108};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h20, Bds,
                     Bds ? 32'h110 : 32'h10C, Bds ? 32'hDEAD_010C : 32'hDEAD_0108};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h20, Bds,
                     Bds ? 32'h110 : 32'h10C, Bds ? 32'hDEAD_010C : 32'hDEAD_0108};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h24, 1'b1, 32'h24, 32'hDEAD_0020};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFC, Bds,
                     Bds ? 32'h28 : 32'h24, Bds ? 32'hDEAD_0024 : 32'hDEAD_0020};
        vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h0,  32'h2152_FFFC};
        vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h4,  1'b1, 32'h4,  32'hDEAD_0000};

        // Reset, with a redirect pending to show reset overrides it.
        ovr_en      = 1'b0;
        ovr_val     = 32'h0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h500;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.pc_sel", {31'b0, pc_sel}, 32'h0);
        chk("rst.addr", imem_addr, 32'h100);
        chk("rst.valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst.pc4", ifid_pc4, 32'h0);
        chk("rst.instr", ifid_instr, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].sel,
                 $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("vec%0d.valid", i), {31'b0, ifid_valid}, {31'b0, vecs[i].valid});
            chk($sformatf("vec%0d.pc4", i), ifid_pc4, vecs[i].pc4);
            chk($sformatf("vec%0d.instr", i), ifid_instr, vecs[i].instr);
        end

        // Move to pc 0x40, then present the branch instruction word.
        step(1'b0, 1'b1, 32'h40, 1'b1, "to40");
        chk("to40.addr", imem_addr, 32'h40);
        ovr_en  = 1'b1;
        ovr_val = 32'hAAAA_0001;

`ifdef BRANCH_DELAY_SLOT_EN
        step(1'b1, 1'b1, 32'h300, 1'b0, "pend1");
        chk("pend1.addr", imem_addr, 32'h40);
        chk("pend1.instr", ifid_instr, 32'hDEAD_0004);
        step(1'b1, 1'b1, 32'h400, 1'b0, "pend2");
        chk("pend2.addr", imem_addr, 32'h40);
        step(1'b0, 1'b0, 32'h0, 1'b1, "pend_go");
        chk("pend_go.addr", imem_addr, 32'h400);
        chk("pend_go.valid", {31'b0, ifid_valid}, 32'h1);
        chk("pend_go.instr", ifid_instr, 32'hAAAA_0001);
        chk("pend_go.pc4", ifid_pc4, 32'h44);
        // Reset while a target is pending must discard it.
        ovr_en = 1'b0;
        step(1'b1, 1'b1, 32'h300, 1'b0, "pend3");
        chk("pend3.addr", imem_addr, 32'h400);
        rst      = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        #1;
        chk("pend_rst.pc_sel", {31'b0, pc_sel}, 32'h0);
        @(posedge clk);
        #1;
        chk("pend_rst.addr", imem_addr, 32'h100);
        chk("pend_rst.valid", {31'b0, ifid_valid}, 32'h0);
        rst = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b0, "post_rst");
        chk("post_rst.addr", imem_addr, 32'h104);
`else
        step(1'b0, 1'b1, 32'h203, 1'b1, "flush");
        chk("flush.addr", imem_addr, 32'h200);
        chk("flush.valid", {31'b0, ifid_valid}, 32'h0);
        chk("flush.instr", ifid_instr, 32'hDEAD_0000);
        chk("flush.pc4", ifid_pc4, 32'h4);
        step(1'b0, 1'b1, 32'h40, 1'b1, "back40");
        chk("back40.addr", imem_addr, 32'h40);
        step(1'b1, 1'b1, 32'h203, 1'b1, "flush_stall");
        chk("flush_stall.addr", imem_addr, 32'h200);
        chk("flush_stall.valid", {31'b0, ifid_valid}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, "after_flush");
        chk("after_flush.addr", imem_addr, 32'h204);
        chk("after_flush.valid", {31'b0, ifid_valid}, 32'h1);
        chk("after_flush.instr", ifid_instr, 32'hAAAA_0001);
        chk("after_flush.pc4", ifid_pc4, 32'h204);
`endif

        // Mid-run reset with stall and redirect both asserted.
        ovr_en      = 1'b0;
        rst         = 1'b1;
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h600;
        #1;
        chk("rst2.pc_sel", {31'b0, pc_sel}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst2.addr", imem_addr, 32'h100);
        chk("rst2.valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst2.pc4", ifid_pc4, 32'h0);
        chk("rst2.instr", ifid_instr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
